led_matrix_scanner: RTL and testbench
=====================================

Name: led_matrix_scanner

Overview:
- Multiplexes a 4x4 intensity framebuffer onto the board's LED matrix: one-hot anode row drive (aled) plus per-column cathode sink enables (kled_sink).
- Top level maps each kled_sink bit onto the OUTPUT_ENABLE of a cathode SB_IO (D_OUT_0 = 0); disabled cathodes float high-Z.
- Per-pixel brightness is time-sliced PWM within each row slot. A blanking interval between rows suppresses ghosting.
- Sits between user logic (framebuffer writes) and the pin-level SB_IO primitives, clocked from the 48 MHz SB_HFOSC.

Parameters:
- PWM_BITS, 4, intensity width per pixel; 2^PWM_BITS PWM slots per row.
- SLOT_CYCLES, 750, clk cycles per PWM slot (>=1).
- BLANK_CYCLES, 96, clk cycles with all outputs off before each row drive (>=1).

Ports:
- clk  in  1  48 MHz system clock
- rst  in  1  asynchronous reset, active-high
- enable  in  1  1 = scanning; 0 = all LEDs off, scan held
- wr_en  in  1  framebuffer write strobe
- wr_addr  in  4  {row[1:0], col[1:0]}
- wr_data  in  PWM_BITS  pixel intensity; 0 = off
- aled  out  4  anode drive, one-hot row, active-high
- kled_sink  out  4  cathode sink enable per column, active-high = lit
- frame_sync  out  1  one-cycle pulse at frame start

Behaviour:
- Reset (async, rst=1): aled=0, kled_sink=0, frame_sync=0, state=BLANK, row=0, slot=0, cycle counter=0, shadow and active buffers cleared to 0.
- All outputs are registered. aled and kled_sink change only on clock edges and never glitch.
- Buffers:
  - Shadow buffer: 16 x PWM_BITS. A write occurs on every clk edge with wr_en=1, independent of state and enable.
  - Active buffer: copied from shadow at frame start, i.e. on the BLANK entry for row 0.
  - Write coincident with the copy cycle: the copy takes the pre-write shadow value. The new value appears the following frame.
- FSM states:
  - IDLE: enable=0. Outputs 0. Counters held at 0, row=0.
  - BLANK: aled=0, kled_sink=0 for exactly BLANK_CYCLES cycles, then go to DRIVE.
  - DRIVE: aled = one-hot(row). For slot s in 0..2^PWM_BITS-1, each lasting SLOT_CYCLES cycles, kled_sink[c] = (active[row][c] > s).
    - After the last slot: row = row+1 (wraps 3->0), then go to BLANK.
- Row period = BLANK_CYCLES + SLOT_CYCLES*2^PWM_BITS. Frame = 4 row periods.
- Duty: intensity 0 is never lit. Max intensity is lit (2^PWM_BITS-1)/2^PWM_BITS of the drive time.
- frame_sync pulses for 1 cycle on the first BLANK cycle of row 0, coincident with the active-buffer copy.
- Enable transitions:
  - enable 1->0: the next cycle enters IDLE with outputs 0, abandoning mid-row/mid-slot. No partial completion.
  - enable 0->1: the next cycle enters BLANK row 0, which includes the frame_sync pulse and the buffer copy.
- Invariants:
  - aled and kled_sink are never nonzero during BLANK or IDLE.
  - Exactly one aled bit is high during DRIVE.
- Reset mid-operation: outputs 0 immediately (async). Frame contents are lost.
- Counter widths: sized with $clog2 of the larger of SLOT_CYCLES and BLANK_CYCLES. Terminal compare is at N-1 with no off-by-one; each phase lasts exactly N cycles.

Decomposition:
- Package doppler_led_pkg:
  - Constants: LED_ROWS=4, LED_COLS=4.
  - Typedef: scan_state_t {IDLE, BLANK, DRIVE}.
  - Function: onehot4(row).
- Sub-module led_framebuf: shadow/active storage, write port, copy strobe, 4-column read of the active row.
- Scanner FSM, counters and PWM compare stay in led_matrix_scanner.

Test Plan (PWM_BITS=2, SLOT_CYCLES=2, BLANK_CYCLES=3; row period 11, frame 44):
- Reset then enable=1 with the buffer empty -> frame_sync at cycle 1; aled sequence 0(3),0001(8),0(3),0010(8)...; kled_sink stays 0 throughout.
- Write addr 0x6 (row1,col2)=2 before frame start -> in the row-1 DRIVE window, aled=0010; kled_sink=0100 for 4 cycles, then 0000 for 4 cycles.
- Pixel values 0,1,2,3 on cols 0..3 of row 0 -> kled_sink high-cycle counts per DRIVE window are 0,2,4,6.
- Write issued on the same cycle as frame_sync -> old value shown for the whole frame; new value shown from the next frame_sync.
- Drop enable mid-slot in row 2 -> next cycle aled=0, kled_sink=0. Re-raise enable -> BLANK row 0 with a frame_sync pulse.
- Assert rst during DRIVE -> aled/kled_sink go 0 asynchronously. After release and enable, all pixels read 0 (kled_sink stays 0).

Source files
------------

// File: rtl/led_matrix_scanner_pkg.sv
// doppler_led_pkg: shared constants, scan states and row decode for the LED matrix scanner.
package doppler_led_pkg;

    localparam int LED_ROWS = 4;
    localparam int LED_COLS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        DRIVE = 2'd2
    } scan_state_t;

    function automatic logic [3:0] onehot4(input logic [1:0] row);
        return 4'b0001 << row;
    endfunction

endpackage

// File: rtl/led_matrix_scanner_if.sv
// led_matrix_scanner_if: framebuffer write port between user logic and the scanner.
interface led_matrix_scanner_if #(
    parameter int PWM_BITS = 4
);

    logic                wr_en;
    logic [3:0]          wr_addr;
    logic [PWM_BITS-1:0] wr_data;

    modport master (output wr_en, wr_addr, wr_data);
    modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/led_matrix_scanner_framebuf.sv
// led_framebuf: shadow framebuffer written by user logic, active copy taken at frame start.
module led_framebuf
    import doppler_led_pkg::*;
#(
    parameter int PWM_BITS = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_wr_en,
    input  logic [3:0]                         i_wr_addr,
    input  logic [PWM_BITS-1:0]                i_wr_data,
    input  logic                               i_copy,
    input  logic [1:0]                         i_rd_row,
    output logic [LED_COLS-1:0][PWM_BITS-1:0]  o_rd_pix
);

    logic [PWM_BITS-1:0] r_shadow [LED_ROWS*LED_COLS];
    logic [PWM_BITS-1:0] r_active [LED_ROWS*LED_COLS];

    // Copy and write share an edge, so the copy always sees the pre-write shadow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '{default: '0};
            r_active <= '{default: '0};
        end else begin
            if (i_wr_en)
                r_shadow[i_wr_addr] <= i_wr_data;
            if (i_copy)
                r_active <= r_shadow;
        end
    end

    for (genvar c = 0; c < LED_COLS; c++) begin : g_col
        assign o_rd_pix[c] = r_active[{i_rd_row, 2'(c)}];
    end

endmodule

// File: rtl/led_matrix_scanner.sv
// led_matrix_scanner: row-multiplexed 4x4 PWM LED matrix driver with blanking between rows.
module led_matrix_scanner
    import doppler_led_pkg::*;
#(
    parameter int PWM_BITS     = 4,
    parameter int SLOT_CYCLES  = 750,
    parameter int BLANK_CYCLES = 96
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    led_matrix_scanner_if.slave   wr,
    output logic [3:0]            aled,
    output logic [LED_COLS-1:0]   kled_sink,
    output logic                  frame_sync
);

    localparam int MAXC = (SLOT_CYCLES > BLANK_CYCLES) ? SLOT_CYCLES : BLANK_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0]       SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0]       BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [PWM_BITS-1:0] SLOT_MAX   = '1;

    scan_state_t               r_state;
    logic [1:0]                r_row;
    logic [PWM_BITS-1:0]       r_slot;
    logic [CW-1:0]             r_cnt;
    logic [3:0]                r_aled;
    logic [LED_COLS-1:0]       r_kled;
    logic                      r_frame_sync;

    logic [LED_COLS-1:0][PWM_BITS-1:0] w_pix;
    logic [PWM_BITS-1:0]               w_slot_inc;
    logic [LED_COLS-1:0]               w_lit_first;
    logic [LED_COLS-1:0]               w_lit_next;

    led_framebuf #(
        .PWM_BITS (PWM_BITS)
    ) u_framebuf (
        .clk       (clk),
        .rst       (rst),
        .i_wr_en   (wr.wr_en),
        .i_wr_addr (wr.wr_addr),
        .i_wr_data (wr.wr_data),
        .i_copy    (r_frame_sync),
        .i_rd_row  (r_row),
        .o_rd_pix  (w_pix)
    );

    assign w_slot_inc = r_slot + PWM_BITS'(1);

    // Cathode pattern for the first slot of a row and for the slot about to start.
    always_comb begin
        w_lit_first = '0;
        w_lit_next  = '0;
        for (int c = 0; c < LED_COLS; c++) begin
            w_lit_first[c] = w_pix[c] != '0;
            w_lit_next[c]  = w_pix[c] > w_slot_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= BLANK;
            r_row        <= '0;
            r_slot       <= '0;
            r_cnt        <= '0;
            r_aled       <= '0;
            r_kled       <= '0;
            r_frame_sync <= 1'b0;
        end else if (!enable) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_slot       <= '0;
            r_cnt        <= '0;
            r_aled       <= '0;
            r_kled       <= '0;
            r_frame_sync <= 1'b0;
        end else begin
            r_frame_sync <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_state      <= BLANK;
                    r_row        <= '0;
                    r_slot       <= '0;
                    r_cnt        <= '0;
                    r_aled       <= '0;
                    r_kled       <= '0;
                    r_frame_sync <= 1'b1;
                end
                BLANK: begin
                    if (r_cnt == BLANK_LAST) begin
                        r_state <= DRIVE;
                        r_cnt   <= '0;
                        r_slot  <= '0;
                        r_aled  <= onehot4(r_row);
                        r_kled  <= w_lit_first;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                DRIVE: begin
                    if (r_cnt == SLOT_LAST) begin
                        r_cnt <= '0;
                        if (r_slot == SLOT_MAX) begin
                            r_state      <= BLANK;
                            r_row        <= r_row + 2'd1;
                            r_slot       <= '0;
                            r_aled       <= '0;
                            r_kled       <= '0;
                            r_frame_sync <= r_row == 2'(LED_ROWS - 1);
                        end else begin
                            r_slot <= w_slot_inc;
                            r_kled <= w_lit_next;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_aled  <= '0;
                    r_kled  <= '0;
                end
            endcase
        end
    end

    assign aled       = r_aled;
    assign kled_sink  = r_kled;
    assign frame_sync = r_frame_sync;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// tb_led_matrix_scanner: scoreboard bench; expectations derived from the row/slot timing formula.
module tb_led_matrix_scanner;

    localparam int PB = 2;
    localparam int SC = 2;
    localparam int BC = 3;
    localparam int ROWP = BC + SC * (1 << PB);
    localparam int FRAME = 4 * ROWP;

    typedef struct {
        logic [3:0] a;
        logic [3:0] k;
        logic       fs;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0;
    logic [3:0] aled;
    logic [3:0] kled_sink;
    logic       frame_sync;

    led_matrix_scanner_if #(.PWM_BITS(PB)) wr ();

    led_matrix_scanner #(
        .PWM_BITS     (PB),
        .SLOT_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .wr         (wr),
        .aled       (aled),
        .kled_sink  (kled_sink),
        .frame_sync (frame_sync)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [PB-1:0] sh  [16];
    logic [PB-1:0] act [16];
    exp_t q [$];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input int k);
        exp_t e;
        int row, p, s;
        row = (k / ROWP) % 4;
        p = k % ROWP;
        e.fs = (k % FRAME) == 0;
        e.a = '0;
        e.k = '0;
        if (p >= BC) begin
            s = (p - BC) / SC;
            e.a = 4'b0001 << row;
            for (int c = 0; c < 4; c++)
                e.k[c] = int'(act[row * 4 + c]) > s;
        end
        return e;
    endfunction

    task automatic push_cycles(input int k0, input int n);
        for (int k = k0; k < k0 + n; k++)
            q.push_back(model(k));
    endtask

    task automatic write_px(input logic [3:0] addr, input logic [PB-1:0] data);
        wr.wr_en = 1'b1;
        wr.wr_addr = addr;
        wr.wr_data = data;
        @(posedge clk);
        #1;
        wr.wr_en = 1'b0;
        sh[addr] = data;
    endtask

    task automatic start_scan();
        enable = 1'b1;
        for (int i = 0; i < 16; i++)
            act[i] = sh[i];
    endtask

    task automatic test_reset();
        wr.wr_en = 1'b0;
        wr.wr_addr = '0;
        wr.wr_data = '0;
        for (int i = 0; i < 16; i++) sh[i] = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({aled, kled_sink, frame_sync} !== 9'b0) begin
            n_err++;
            $display("FAIL reset_hold: aled=%b kled=%b fs=%b want all 0", aled, kled_sink, frame_sync);
        end
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({aled, kled_sink, frame_sync} !== 9'b0) begin
            n_err++;
            $display("FAIL idle_after_reset: aled=%b kled=%b fs=%b want all 0", aled, kled_sink, frame_sync);
        end
    endtask

    task automatic test_empty_frame();
        exp_t e;
        start_scan();
        push_cycles(0, FRAME + ROWP);
        for (int k = 0; k < FRAME + ROWP; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_cmp++;
            if (aled !== e.a || kled_sink !== e.k || frame_sync !== e.fs) begin
                n_err++;
                $display("FAIL empty_frame k=%0d: got aled=%b kled=%b fs=%b want aled=%b kled=%b fs=%b",
                         k, aled, kled_sink, frame_sync, e.a, e.k, e.fs);
            end
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single_pixel();
        exp_t e;
        int lit;
        lit = 0;
        write_px(4'h6, 2'd2);
        start_scan();
        push_cycles(0, FRAME);
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (aled == 4'b0010 && kled_sink == 4'b0100) lit++;
            n_cmp++;
            if (aled !== e.a || kled_sink !== e.k || frame_sync !== e.fs) begin
                n_err++;
                $display("FAIL single_pixel k=%0d: got aled=%b kled=%b fs=%b want aled=%b kled=%b fs=%b",
                         k, aled, kled_sink, frame_sync, e.a, e.k, e.fs);
            end
        end
        n_cmp++;
        if (lit != 4) begin
            n_err++;
            $display("FAIL single_pixel_count: lit cycles=%0d want 4", lit);
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_duty();
        exp_t e;
        int cnt [4];
        int want [4];
        want = '{0, 2, 4, 6};
        cnt = '{0, 0, 0, 0};
        for (int c = 0; c < 4; c++)
            write_px(4'(c), PB'(c));
        start_scan();
        push_cycles(0, FRAME);
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            for (int c = 0; c < 4; c++)
                if (aled == 4'b0001 && kled_sink[c]) cnt[c]++;
            n_cmp++;
            if (aled !== e.a || kled_sink !== e.k || frame_sync !== e.fs) begin
                n_err++;
                $display("FAIL duty k=%0d: got aled=%b kled=%b fs=%b want aled=%b kled=%b fs=%b",
                         k, aled, kled_sink, frame_sync, e.a, e.k, e.fs);
            end
        end
        for (int c = 0; c < 4; c++) begin
            n_cmp++;
            if (cnt[c] != want[c]) begin
                n_err++;
                $display("FAIL duty_count col%0d: lit=%0d want %0d", c, cnt[c], want[c]);
            end
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_write_on_sync();
        exp_t e;
        int col0 [2];
        col0 = '{0, 0};
        start_scan();
        push_cycles(0, FRAME);
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            if (aled == 4'b0001 && kled_sink[0]) col0[k / FRAME]++;
            n_cmp++;
            if (aled !== e.a || kled_sink !== e.k || frame_sync !== e.fs) begin
                n_err++;
                $display("FAIL write_on_sync k=%0d: got aled=%b kled=%b fs=%b want aled=%b kled=%b fs=%b",
                         k, aled, kled_sink, frame_sync, e.a, e.k, e.fs);
            end
            if (k == 0) begin
                wr.wr_en = 1'b1;
                wr.wr_addr = 4'h0;
                wr.wr_data = 2'd3;
                sh[0] = 2'd3;
            end else if (k == 1) begin
                wr.wr_en = 1'b0;
            end else if (k == FRAME - 1) begin
                for (int i = 0; i < 16; i++) act[i] = sh[i];
                push_cycles(FRAME, FRAME);
            end
        end
        n_cmp++;
        if (col0[0] != 0 || col0[1] != 6) begin
            n_err++;
            $display("FAIL write_on_sync_count: col0 lit old=%0d new=%0d want 0 and 6", col0[0], col0[1]);
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_enable_drop();
        exp_t e;
        int stop;
        stop = 2 * ROWP + BC + 1;
        start_scan();
        push_cycles(0, stop + 1);
        for (int k = 0; k <= stop; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_cmp++;
            if (aled !== e.a || kled_sink !== e.k || frame_sync !== e.fs) begin
                n_err++;
                $display("FAIL enable_drop_pre k=%0d: got aled=%b kled=%b fs=%b want aled=%b kled=%b fs=%b",
                         k, aled, kled_sink, frame_sync, e.a, e.k, e.fs);
            end
        end
        enable = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if ({aled, kled_sink, frame_sync} !== 9'b0) begin
                n_err++;
                $display("FAIL enable_drop_off: aled=%b kled=%b fs=%b want all 0", aled, kled_sink, frame_sync);
            end
        end
        start_scan();
        push_cycles(0, ROWP + 1);
        for (int k = 0; k <= ROWP; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_cmp++;
            if (aled !== e.a || kled_sink !== e.k || frame_sync !== e.fs) begin
                n_err++;
                $display("FAIL enable_reraise k=%0d: got aled=%b kled=%b fs=%b want aled=%b kled=%b fs=%b",
                         k, aled, kled_sink, frame_sync, e.a, e.k, e.fs);
            end
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        start_scan();
        push_cycles(0, BC + 2);
        for (int k = 0; k < BC + 2; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_cmp++;
            if (aled !== e.a || kled_sink !== e.k || frame_sync !== e.fs) begin
                n_err++;
                $display("FAIL reset_mid_pre k=%0d: got aled=%b kled=%b fs=%b want aled=%b kled=%b fs=%b",
                         k, aled, kled_sink, frame_sync, e.a, e.k, e.fs);
            end
        end
        #2;
        rst = 1'b1;
        enable = 1'b0;
        #1;
        n_cmp++;
        if (aled !== 4'b0 || kled_sink !== 4'b0) begin
            n_err++;
            $display("FAIL reset_async: aled=%b kled=%b want 0000 0000", aled, kled_sink);
        end
        for (int i = 0; i < 16; i++) sh[i] = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_scan();
        push_cycles(0, FRAME);
        for (int k = 0; k < FRAME; k++) begin
            @(posedge clk);
            #1;
            e = q.pop_front();
            n_cmp++;
            if (aled !== e.a || kled_sink !== e.k || frame_sync !== e.fs) begin
                n_err++;
                $display("FAIL reset_mid_post k=%0d: got aled=%b kled=%b fs=%b want aled=%b kled=%b fs=%b",
                         k, aled, kled_sink, frame_sync, e.a, e.k, e.fs);
            end
        end
        enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_single_pixel();
        test_duty();
        test_write_on_sync();
        test_enable_drop();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
